// File: rtl/ld_use_scoreboard.sv
// rtl/ld_use_scoreboard.sv - load-use interlock scoreboard for the decode stage
//
// Tracks, per architectural register, how many issued loads are still waiting
// for their data to become forwardable, and holds decode while the decode
// instruction reads such a register (or would overflow its counter).
//
// Optional feature macro: SB_PERF_CNT_EN (adds stall_cycles / stall_events).
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   ds_valid              decode holds a valid instruction
//   ds_rj, ds_rk          decode source register addresses
//   ds_use_rj, ds_use_rk  decode instruction reads rj / second source
//   ds_is_load            decode instruction is ld.w
//   ds_waddr              decode destination register
//   es_allow_in           EXE can accept an instruction
//   ld_done, ld_done_waddr  a tracked load's data became forwardable
//   flush                 synchronous discard of all tracking
//   stall                 hold decode
//   issue                 decode instruction advances to EXE this cycle
//   ovf_err               sticky: ld_done seen on a zero counter
//   busy                  any counter non-zero
//   stall_cycles          (SB_PERF_CNT_EN) cycles with stall=1
//   stall_events          (SB_PERF_CNT_EN) stall rising edges
module ld_use_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_valid,
    input  logic [4:0]  ds_rj,
    input  logic [4:0]  ds_rk,
    input  logic        ds_use_rj,
    input  logic        ds_use_rk,
    input  logic        ds_is_load,
    input  logic [4:0]  ds_waddr,
    input  logic        es_allow_in,
    input  logic        ld_done,
    input  logic [4:0]  ld_done_waddr,
    input  logic        flush,
    output logic        stall,
    output logic        issue,
    output logic        ovf_err,
    output logic        busy
`ifdef SB_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] stall_events
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Full 32-entry view of the counters; r0 and any register beyond NREG
    // read as zero so the 5-bit addresses can index it directly.
    logic [CNT_W-1:0] w_cnt [32];

    logic w_hazard1;
    logic w_hazard2;
    logic w_full;
    logic w_load_issue;
    logic w_underflow;
    logic r_ovf_err;

    assign w_cnt[0] = '0;

    for (genvar g = 1; g < 32; g++) begin : g_reg
        if (g < NREG) begin : g_tracked
            logic [CNT_W-1:0] r_cnt;
            logic             w_inc;
            logic             w_dec;

            assign w_inc = w_load_issue & (ds_waddr == 5'(g));
            assign w_dec = ld_done & (ld_done_waddr == 5'(g));

            // Flush wins over any inc/dec in the same cycle. A decrement on a
            // zero counter leaves it at zero (the error is flagged centrally).
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (flush) begin
                    r_cnt <= '0;
                end else if (w_inc & ~w_dec) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_dec & ~w_inc & (r_cnt != '0)) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign w_cnt[g] = r_cnt;
        end else begin : g_absent
            assign w_cnt[g] = '0;
        end
    end

    assign w_hazard1 = ds_use_rj & (ds_rj != 5'd0) & (w_cnt[ds_rj] != '0);
    assign w_hazard2 = ds_use_rk & (ds_rk != 5'd0) & (w_cnt[ds_rk] != '0);
    assign w_full    = ds_is_load & (ds_waddr != 5'd0) & (w_cnt[ds_waddr] == CNT_MAX);

    // stall must not look at es_allow_in, otherwise decode/EXE handshakes
    // could form a combinational loop.
    assign stall        = ds_valid & (w_hazard1 | w_hazard2 | w_full);
    assign issue        = ds_valid & ~stall & es_allow_in;
    assign w_load_issue = issue & ds_is_load & (ds_waddr != 5'd0);

    // A completion that coincides with a new load to the same register nets
    // out to no change, so it is not an underflow even on a zero counter.
    assign w_underflow = ld_done & (ld_done_waddr != 5'd0)
                       & (w_cnt[ld_done_waddr] == '0)
                       & ~(w_load_issue & (ds_waddr == ld_done_waddr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_err <= 1'b0;
        end else if (w_underflow) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign ovf_err = r_ovf_err;

    always_comb begin
        busy = 1'b0;
        for (int r = 1; r < 32; r++) begin
            busy = busy | (w_cnt[r] != '0);
        end
    end

`ifdef SB_PERF_CNT_EN
    logic        r_stall_d;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_stall_events;

    // Not cleared by flush: these describe the whole run, not pipeline state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_d      <= 1'b0;
            r_stall_cycles <= '0;
            r_stall_events <= '0;
        end else begin
            r_stall_d <= stall;
            if (stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (stall & ~r_stall_d) begin
                r_stall_events <= r_stall_events + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign stall_events = r_stall_events;
`endif

endmodule

// File: tb/tb_ld_use_scoreboard.sv
// tb/tb_ld_use_scoreboard.sv - scoreboard testbench for ld_use_scoreboard
module tb_ld_use_scoreboard;

    localparam int MAXCNT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ds_valid = 0, ds_use_rj = 0, ds_use_rk = 0, ds_is_load = 0;
    logic [4:0]  ds_rj = 0, ds_rk = 0, ds_waddr = 0, ld_done_waddr = 0;
    logic        es_allow_in = 0, ld_done = 0, flush = 0;
    logic        stall, issue, ovf_err, busy;
`ifdef SB_PERF_CNT_EN
    logic [31:0] stall_cycles, stall_events;
`endif

    ld_use_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .ds_valid(ds_valid), .ds_rj(ds_rj), .ds_rk(ds_rk),
        .ds_use_rj(ds_use_rj), .ds_use_rk(ds_use_rk),
        .ds_is_load(ds_is_load), .ds_waddr(ds_waddr),
        .es_allow_in(es_allow_in), .ld_done(ld_done),
        .ld_done_waddr(ld_done_waddr), .flush(flush),
        .stall(stall), .issue(issue), .ovf_err(ovf_err), .busy(busy)
`ifdef SB_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .stall_events(stall_events)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       stall;
        bit       issue;
        bit       busy;
        bit       ovf;
        bit [31:0] cyc;
        bit [31:0] evt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: outstanding-load count per register.
    int   m_cnt [32];
    bit   m_ovf;
    bit [31:0] m_cyc, m_evt;
    bit   m_prev_stall;

    task automatic chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares each cycle's outputs against what stimulus queued.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", stall, e.stall);
            chk("issue", issue, e.issue);
            chk("busy", busy, e.busy);
            chk("ovf_err", ovf_err, e.ovf);
`ifdef SB_PERF_CNT_EN
            chk("stall_cycles", stall_cycles, e.cyc);
            chk("stall_events", stall_events, e.evt);
`endif
        end
    end

    task automatic model_clear();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_ovf = 0; m_cyc = 0; m_evt = 0; m_prev_stall = 0;
    endtask

    task automatic set_idle();
        ds_valid = 0; ds_use_rj = 0; ds_use_rk = 0; ds_is_load = 0;
        ds_rj = 0; ds_rk = 0; ds_waddr = 0; es_allow_in = 0;
        ld_done = 0; ld_done_waddr = 0; flush = 0;
    endtask

    // One clock cycle: drive inputs, queue the expected response, then
    // advance the model across the coming clock edge.
    task automatic step(input bit v, input int rj, input bit urj, input int rk, input bit urk,
                        input bit ld, input int wa, input bit al,
                        input bit dn, input int dwa, input bit fl);
        exp_t e;
        bit   hz, st, is;
        int   inc_r, dec_r;
        @(posedge clk); #1;
        ds_valid = v; ds_rj = 5'(rj); ds_use_rj = urj; ds_rk = 5'(rk); ds_use_rk = urk;
        ds_is_load = ld; ds_waddr = 5'(wa); es_allow_in = al;
        ld_done = dn; ld_done_waddr = 5'(dwa); flush = fl;

        hz = (urj && rj != 0 && m_cnt[rj] > 0) || (urk && rk != 0 && m_cnt[rk] > 0)
          || (ld && wa != 0 && m_cnt[wa] == MAXCNT);
        st = v && hz;
        is = v && !st && al;
        e.stall = st; e.issue = is; e.ovf = m_ovf; e.cyc = m_cyc; e.evt = m_evt;
        e.busy = 0;
        for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) e.busy = 1;
        q.push_back(e);

        inc_r = (is && ld && wa != 0) ? wa : -1;
        dec_r = (dn && dwa != 0) ? dwa : -1;
        if (dec_r >= 0 && dec_r != inc_r && m_cnt[dec_r] == 0) m_ovf = 1;
        if (fl) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else if (inc_r != dec_r) begin
            if (inc_r >= 0) m_cnt[inc_r] = m_cnt[inc_r] + 1;
            if (dec_r >= 0 && m_cnt[dec_r] > 0) m_cnt[dec_r] = m_cnt[dec_r] - 1;
        end
        if (st) m_cyc = m_cyc + 1;
        if (st && !m_prev_stall) m_evt = m_evt + 1;
        m_prev_stall = st;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Load issue to register wa.
    task automatic ldw(input int wa);
        step(1, 0, 0, 0, 0, 1, wa, 1, 0, 0, 0);
    endtask

    // Reader of register r, optionally with a ld_done to dwa.
    task automatic rd(input int r, input bit dn, input int dwa);
        step(1, r, 1, 7, 0, 0, 6, 1, dn, dwa, 0);
    endtask

    initial begin
        model_clear();
        set_idle();
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Reset state, then load followed by dependent use.
        idle();
        ldw(5);
        rd(5, 0, 0);
        rd(5, 1, 5);
        rd(5, 0, 0);
        idle();

        // r0 is never tracked.
        ldw(0);
        rd(0, 0, 0);
        idle();

        // Simultaneous inc/dec on a register holding one load.
        ldw(3);
        step(1, 0, 0, 0, 0, 1, 3, 1, 1, 3, 0);
        rd(3, 0, 0);
        rd(3, 1, 3);
        rd(3, 0, 0);

        // Saturation: fourth load to r9 waits for a completion.
        ldw(9); ldw(9); ldw(9);
        ldw(9);
        step(1, 0, 0, 0, 0, 1, 9, 1, 1, 9, 0);
        ldw(9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        idle();

        // Flush clears tracking; a later completion underflows, sticky.
        ldw(4); ldw(4);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();

        // 3-cycle stall, then async reset in the middle of another stall.
        ldw(12);
        rd(12, 0, 0); rd(12, 0, 0); rd(12, 1, 12);
        rd(12, 0, 0);
        ldw(13);
        rd(13, 0, 0);
        @(negedge clk); #2;
        set_idle();
        reset = 1;
        #1;
        chk("async_reset_stall", stall, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_ovf", ovf_err, 0);
        model_clear();
        @(posedge clk); #1 reset = 0;
        idle();

        // Randomized traffic on a small register window to force hazards.
        for (int i = 0; i < 3000; i++) begin
            int  pick, dwa, rj, rk, wa;
            bit  dn;
            rj = $urandom_range(0, 7); rk = $urandom_range(0, 7); wa = $urandom_range(0, 7);
            dn = ($urandom_range(0, 2) == 0);
            dwa = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) begin
                pick = $urandom_range(1, 7);
                for (int k = 0; k < 8; k++) begin
                    if (m_cnt[((pick + k) % 7) + 1] > 0) begin
                        dwa = ((pick + k) % 7) + 1;
                        break;
                    end
                end
            end
            step($urandom_range(0, 3) != 0, rj, $urandom_range(0, 1), rk, $urandom_range(0, 1),
                 $urandom_range(0, 1), wa, $urandom_range(0, 3) != 0,
                 dn, dwa, $urandom_range(0, 39) == 0);
        end
        idle();
        @(posedge clk); #1 set_idle();
        @(negedge clk); #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ld_use_scoreboard.md
Name: ld_use_scoreboard

Overview:
- Load-use interlock controller for the 5-stage LA32R pipeline. Sits beside the decode stage and drives its `stall` input.
- Tracks destination registers of loads already issued to EXE whose data is not yet forwardable. Holds decode while a source operand depends on such a load.
- ALU results are forwarded from EXE/MEM and never tracked here; only loads create interlocks.

Parameters:
- NREG, 32, number of architectural registers (r0 hardwired zero, never tracked).
- CNT_W, 2, width of per-register outstanding-load counter; max outstanding per register = 2^CNT_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ds_valid  in  1  decode stage holds a valid instruction
- ds_rj  in  5  source register 1 address of the decode instruction
- ds_rk  in  5  source register 2 address (rd for st/beq/bne, as muxed by decode)
- ds_use_rj  in  1  decode instruction reads rj
- ds_use_rk  in  1  decode instruction reads the second source
- ds_is_load  in  1  decode instruction is ld.w
- ds_waddr  in  5  decode destination register
- es_allow_in  in  1  EXE stage can accept
- ld_done  in  1  a tracked load's data is now forwardable (MEM result valid)
- ld_done_waddr  in  5  destination of that load
- flush  in  1  synchronous pipeline flush: discard all tracking
- stall  out  1  hold decode (to decode `stall`)
- issue  out  1  decode instruction advances to EXE this cycle
- ovf_err  out  1  sticky: ld_done on zero counter (underflow)
- busy  out  1  any counter non-zero

Behaviour:
- State: cnt[1..NREG-1], each CNT_W bits; cnt[0] absent/constant 0.
- hazard1 = ds_use_rj & (ds_rj!=0) & cnt[ds_rj]!=0; hazard2 likewise for ds_rk.
- full = ds_is_load & (ds_waddr!=0) & cnt[ds_waddr]==max.
- stall = ds_valid & (hazard1 | hazard2 | full). Combinational from registered counters and inputs; no dependency on es_allow_in (no loop).
- issue = ds_valid & ~stall & es_allow_in.
- Per-register update each posedge, for register r:
  - inc = issue & ds_is_load & ds_waddr==r.
  - dec = ld_done & ld_done_waddr==r.
  - inc&dec: unchanged. inc only: +1. dec only: -1.
  - dec with cnt==0: counter stays 0 and ovf_err<=1.
- ld_done for r0: ignored, no error.
- flush has priority over inc/dec: all counters <=0 same edge; ovf_err unaffected; issue in the flush cycle is not recorded.
- Hazard uses the pre-edge count. A ld_done to the stalled register in cycle N releases the stall in cycle N+1 (1-cycle latency from ld_done to stall deassert).
- A load issuing in cycle N causes a stall for a dependent decode instruction in cycle N+1.
- Reset (async, any time, including mid-stall): all counters 0, ovf_err=0, so stall=0, busy=0. issue follows its equation.
- busy = OR of all counters.

Optional Feature:
- SB_PERF_CNT_EN defined: adds outputs stall_cycles[31:0] and stall_events[31:0].
  - stall_cycles increments every cycle stall=1.
  - stall_events increments on each 0->1 stall edge.
  - Both wrap at 2^32, reset to 0, and are not cleared by flush.
- Undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Load then dependent use:
  - Stimulus: issue ld.w r5 (es_allow_in=1); next cycle decode add r6,r5,r7 with use_rj=1.
  - Response: stall=1, issue=0. Assert ld_done waddr=5 → stall=0 next cycle, issue=1, cnt[5]=0.
- r0 immunity:
  - Stimulus: ld.w r0 issued; next instruction reads r0.
  - Response: stall=0, busy=0.
- Simultaneous inc/dec:
  - Stimulus: cnt[3]=1; same cycle issue ld.w r3 and ld_done r3.
  - Response: cnt[3] stays 1, stall for a reader of r3.
- Saturation:
  - Stimulus: CNT_W=2; three loads to r9 (use flags 0).
  - Response: a fourth ld.w r9 in decode gets stall=1 until one ld_done r9.
- Flush and underflow:
  - Stimulus: cnt[4]=2 with flush=1.
  - Response: busy=0 next cycle. Then ld_done r4 → ovf_err=1, and it stays 1 through a later flush.
- Async reset mid-stall:
  - Stimulus: assert reset between edges while stall=1.
  - Response: stall=0 immediately, counters 0.
  - With SB_PERF_CNT_EN: a 3-cycle stall gives stall_cycles=3, stall_events=1.
